if_program_ctrl: RTL

Sequencer for the fetch stage and its instruction memory. It receives command and data bytes over a byte stream from the UART receiver. It assembles little-endian 32-bit instructions and writes them into instruction memory while execution is disabled. It then gates the pipeline enable for continuous runs or for single-cycle steps, until the pipeline reports that the halt instruction has retired.

---
 rtl/if_program_ctrl_if.sv | 25 ++
 rtl/if_program_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/if_program_ctrl_if.sv
// Byte stream from the UART receiver plus the fetch-stage write/enable bus.
// The master side is the host/pipeline; the slave side is the program controller.
interface if_program_ctrl_if #(
    parameter int INST_SZ = 32,
    parameter int MEM_SZ  = 10
) ();
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic               halt_done;
    logic               write;
    logic [MEM_SZ-1:0]  wr_addr;
    logic [INST_SZ-1:0] instruction;
    logic               enable;

    modport master (
        output rx_data, rx_valid, halt_done,
        input  rx_ready, write, wr_addr, instruction, enable
    );

    modport slave (
        input  rx_data, rx_valid, halt_done,
        output rx_ready, write, wr_addr, instruction, enable
    );
endinterface

// File: rtl/if_program_ctrl.sv
// Fetch-stage sequencer: loads little-endian instruction words from a byte stream
// into instruction memory, then gates pipeline enable for runs or single steps.
module if_program_ctrl #(
    parameter int                 INST_SZ   = 32,
    parameter int                 MEM_SZ    = 10,
    parameter logic [INST_SZ-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    if_program_ctrl_if.slave  bus,
    output logic [MEM_SZ:0]   o_inst_count,
    output logic              o_load_ovf,
    output logic              o_cmd_err,
    output logic [2:0]        o_state
);
    localparam int BYTES  = INST_SZ / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_QUIT = 8'h51;

    localparam logic [MEM_SZ-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_WRITE      = 3'd2,
        S_RUN        = 3'd3,
        S_STEP       = 3'd4,
        S_STEP_PULSE = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t              state_reg, state_next;
    logic [BIDX_W-1:0]   byte_idx_reg;
    logic [MEM_SZ-1:0]   addr_reg;
    logic [INST_SZ-1:0]  word_reg;
    logic [MEM_SZ:0]     count_reg;
    logic                ovf_reg;
    logic                cmd_err_reg;
    logic                rx_ready;
    logic                take;
    logic                start_load;

    // Ready depends on state only, so no combinational path from the byte stream
    assign rx_ready = (state_reg == S_IDLE) || (state_reg == S_LOAD) ||
                      (state_reg == S_STEP) || (state_reg == S_DONE);
    assign take       = bus.rx_valid && rx_ready;
    assign start_load = take && (bus.rx_data == CMD_LOAD) &&
                        ((state_reg == S_IDLE) || (state_reg == S_DONE));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (take) begin
                    case (bus.rx_data)
                        CMD_LOAD: state_next = S_LOAD;
                        CMD_RUN:  state_next = S_RUN;
                        CMD_STEP: state_next = S_STEP;
                        default:  state_next = state_reg;
                    endcase
                end
            end
            S_LOAD: begin
                if (take && (byte_idx_reg == BIDX_W'(BYTES - 1)))
                    state_next = S_WRITE;
            end
            S_WRITE: begin
                if ((word_reg == HALT_WORD) || (addr_reg == ADDR_MAX))
                    state_next = S_IDLE;
                else
                    state_next = S_LOAD;
            end
            S_RUN: begin
                if (bus.halt_done)
                    state_next = S_DONE;
            end
            S_STEP: begin
                // A retired halt takes priority over any pending step command
                if (bus.halt_done)
                    state_next = S_DONE;
                else if (take && (bus.rx_data == CMD_NEXT))
                    state_next = S_STEP_PULSE;
                else if (take && (bus.rx_data == CMD_QUIT))
                    state_next = S_IDLE;
            end
            S_STEP_PULSE: state_next = S_STEP;
            default:      state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            byte_idx_reg <= '0;
            addr_reg     <= '0;
            word_reg     <= '0;
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
            cmd_err_reg  <= 1'b0;
        end else begin
            if (start_load) begin
                byte_idx_reg <= '0;
                addr_reg     <= '0;
                count_reg    <= '0;
                ovf_reg      <= 1'b0;
            end
            if ((state_reg == S_IDLE) && take &&
                (bus.rx_data != CMD_LOAD) && (bus.rx_data != CMD_RUN) &&
                (bus.rx_data != CMD_STEP)) begin
                cmd_err_reg <= 1'b1;
            end
            if ((state_reg == S_LOAD) && take) begin
                word_reg     <= {bus.rx_data, word_reg[INST_SZ-1:8]};
                byte_idx_reg <= byte_idx_reg + BIDX_W'(1);
            end
            if (state_reg == S_WRITE) begin
                count_reg <= count_reg + (MEM_SZ+1)'(1);
                // The last address is held rather than wrapped; the load ends here anyway
                if (addr_reg != ADDR_MAX)
                    addr_reg <= addr_reg + MEM_SZ'(1);
                if ((word_reg != HALT_WORD) && (addr_reg == ADDR_MAX))
                    ovf_reg <= 1'b1;
            end
        end
    end

    assign bus.rx_ready    = rx_ready;
    assign bus.write       = (state_reg == S_WRITE);
    assign bus.wr_addr     = addr_reg;
    assign bus.instruction = word_reg;
    assign bus.enable      = (state_reg == S_RUN) || (state_reg == S_STEP_PULSE);
    assign o_inst_count    = count_reg;
    assign o_load_ovf      = ovf_reg;
    assign o_cmd_err       = cmd_err_reg;
    assign o_state         = state_reg;
endmodule
